// File: rtl/uart_pkg.sv
// Shared types for the board UART transmit and receive paths.
//   tx_state_t : transmit handshake FSM states
//   byte_t     : one UART data byte
package uart_pkg;

    typedef logic [7:0] byte_t;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_SETUP,
        TX_STROBE,
        TX_WAIT_ACK,
        TX_WAIT_RDY
    } tx_state_t;

endpackage

// File: rtl/byte_fifo.sv
// Small synchronous byte FIFO, shared by the tx and rx sides.
// Ports:
//   clk_i    : clock, rising edge
//   rst_i    : synchronous active-high reset (pointers and count only)
//   push_i   : write din_i this cycle (ignored while full)
//   pop_i    : advance read pointer this cycle (ignored while empty)
//   din_i    : byte to write
//   dout_o   : byte at the head of the FIFO (valid while !empty_o)
//   full_o   : DEPTH bytes held
//   empty_o  : no bytes held
//   count_o  : number of bytes held, 0..DEPTH
module byte_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   push_i,
    input  logic                   pop_i,
    input  byte_t                  din_i,
    output byte_t                  dout_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int PTR_W = $clog2(DEPTH);

    byte_t            mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W:0]   count_q;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (count_q == (PTR_W+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign dout_o  = mem_q[rd_ptr_q];

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    // Pointers are exactly log2(DEPTH) bits, so they wrap without extra logic.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage carries no reset; stale entries are unreachable once the pointers clear.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= din_i;
    end

endmodule

// File: rtl/uart_tx_driver.sv
// Transmit-side driver for the board UART port. Bytes pushed by user logic
// are queued in a byte_fifo and handed to the host one at a time using a
// txdata/txclk strobe paced by txready.
// Ports:
//   hz100    : system clock, rising edge
//   reset    : synchronous active-high reset
//   push/din : enqueue a byte
//   full     : FIFO holds DEPTH bytes
//   empty    : FIFO holds no bytes
//   overflow : sticky, a push arrived while full (byte dropped)
//   busy     : handshake FSM not idle
//   sent_cnt : bytes handed to the host, wraps at 256
//   txdata   : byte presented to the host
//   txclk    : host latches txdata while high
//   txready  : host can accept a byte
module uart_tx_driver
    import uart_pkg::*;
#(
    parameter int DEPTH       = 4,
    parameter int STROBE_LEN  = 2,
    parameter int ACK_TIMEOUT = 8
) (
    input  logic       hz100,
    input  logic       reset,
    input  logic       push,
    input  byte_t      din,
    output logic       full,
    output logic       empty,
    output logic       overflow,
    output logic       busy,
    output logic [7:0] sent_cnt,
    output byte_t      txdata,
    output logic       txclk,
    input  logic       txready
);

    localparam int CNT_MAX = (STROBE_LEN > ACK_TIMEOUT) ? STROBE_LEN : ACK_TIMEOUT;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    tx_state_t              state_q;
    logic [CNT_W-1:0]       cnt_q;
    byte_t                  txdata_q;
    logic                   txclk_q;
    logic                   busy_q;
    logic [7:0]             sent_cnt_q;
    logic                   overflow_q;
    logic                   overflow_d;

    byte_t                  fifo_dout;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic [$clog2(DEPTH):0] fifo_count;
    logic                   pop;

    // The head byte is taken only when leaving IDLE toward the host.
    assign pop = (state_q == TX_IDLE) && (fifo_count != '0) && txready;

    byte_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (hz100),
        .rst_i   (reset),
        .push_i  (push),
        .pop_i   (pop),
        .din_i   (din),
        .dout_o  (fifo_dout),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    assign full     = fifo_full;
    assign empty    = fifo_empty;
    assign overflow = overflow_q;
    assign busy     = busy_q;
    assign sent_cnt = sent_cnt_q;
    assign txdata   = txdata_q;
    assign txclk    = txclk_q;

    assign overflow_d = overflow_q || (push && fifo_full);

    always_ff @(posedge hz100) begin
        if (reset) overflow_q <= 1'b0;
        else       overflow_q <= overflow_d;
    end

    // Handshake FSM. cnt_q times the strobe width in STROBE and the ack
    // window in WAIT_ACK; it restarts from zero on entry to either state.
    // txready is not looked at in SETUP/STROBE, so a started strobe always completes.
    always_ff @(posedge hz100) begin
        if (reset) begin
            state_q    <= TX_IDLE;
            cnt_q      <= '0;
            txdata_q   <= '0;
            txclk_q    <= 1'b0;
            busy_q     <= 1'b0;
            sent_cnt_q <= '0;
        end else begin
            case (state_q)
                TX_IDLE: begin
                    if (pop) begin
                        state_q  <= TX_SETUP;
                        txdata_q <= fifo_dout;
                        busy_q   <= 1'b1;
                    end
                end
                TX_SETUP: begin
                    state_q <= TX_STROBE;
                    txclk_q <= 1'b1;
                    cnt_q   <= '0;
                end
                TX_STROBE: begin
                    if (cnt_q == CNT_W'(STROBE_LEN - 1)) begin
                        state_q    <= TX_WAIT_ACK;
                        txclk_q    <= 1'b0;
                        cnt_q      <= '0;
                        sent_cnt_q <= sent_cnt_q + 8'd1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                TX_WAIT_ACK: begin
                    // A host that never drops txready is assumed to have taken the byte.
                    if (!txready) begin
                        state_q <= TX_WAIT_RDY;
                    end else if (cnt_q == CNT_W'(ACK_TIMEOUT)) begin
                        state_q <= TX_IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                TX_WAIT_RDY: begin
                    if (txready) begin
                        state_q <= TX_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= TX_IDLE;
                    txclk_q <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

endmodule
